// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// FSM encoding, default sizes and frame length.
package uart_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int DATA_BITS_DEF = 8;

   // start + payload + stop, no parity
   localparam int FRAME_BITS = DATA_BITS_DEF + 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr_i, wrapping,
// and returns the first requester as one-hot plus index.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         vld_o
);

   // first active request at or after the pointer wins
   always_comb begin
      int j;
      logic [W-1:0] jw;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j     = 0;
      jw    = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         jw = W'(j);
         if (!vld_o && req_i[jw]) begin
            gnt_o[jw] = 1'b1;
            idx_o     = jw;
            vld_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shared UART transmitter: round-robin picks a requester,
// then one 8N1-style frame is serialised on baud ticks.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_enb,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    owner
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   state_e                 state_q, state_d;
   logic                   tx_q, tx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;

   logic [NUM_REQ-1:0]     win;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_vld;
   logic [DATA_BITS-1:0]   pay [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pay
      assign pay[g] = req_data[g*DATA_BITS +: DATA_BITS];
   end

   rr_arbiter #(
      .N (NUM_REQ),
      .W (IDX_W)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (win),
      .idx_o (win_idx),
      .vld_o (win_vld)
   );

   // next-state: grant in IDLE, then one line change per tick;
   // the tick landing in the grant-pulse cycle is ignored in ARM
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               gnt_d   = win;
               shreg_d = pay[win_idx];
               owner_d = win_idx;
               ptr_d   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (tx_enb && gnt_q == '0) begin
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_enb) begin
               tx_d    = shreg_q[0];
               cnt_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_enb) begin
               if (cnt_q == CNT_LAST) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tx_enb) begin
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // state registers; reset aborts any frame with the line idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         shreg_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt   = gnt_q;
   assign tx    = tx_q;
   assign owner = owner_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: grants, framing,
// round-robin order, tick coincidence and mid-frame reset.
module tb_uart_tx_scheduler;
   import uart_pkg::*;

   localparam int NR  = 4;
   localparam int DB  = 8;
   localparam int PER = 16;

   logic        clk;
   logic        reset;
   logic        tx_enb;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        tx;
   logic        busy;
   logic [1:0]  owner;

   int   n_vec = 0;
   int   n_err = 0;
   logic tick_en = 1'b0;
   logic tick_force = 1'b0;
   int   div = 0;

   uart_tx_scheduler #(
      .NUM_REQ   (NR),
      .DATA_BITS (DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_enb   (tx_enb),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .tx       (tx),
      .busy     (busy),
      .owner    (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // baud tick: every PER clocks when enabled, else forced level
   initial begin
      tx_enb = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_en) begin
            tx_enb = (div == PER - 1);
            div    = (div == PER - 1) ? 0 : div + 1;
         end else begin
            tx_enb = tick_force;
            div    = 0;
         end
      end
   end

   // waits for the next tick edge; ok=0 on timeout or if tx/gnt
   // moved between ticks
   task automatic tick_wait(output bit ok);
      logic hold;
      bit   found;
      bit   stable;
      hold   = tx;
      found  = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < 4 * PER; c++) begin
         @(posedge clk);
         if (tx_enb) begin
            #1;
            found = 1'b1;
            break;
         end
         #1;
         if (tx !== hold || gnt !== 4'b0000) stable = 1'b0;
      end
      ok = found && stable;
   endtask

   task automatic wait_gnt(input logic [3:0] eg, input logic [1:0] eo,
                           input int bound, input string nm);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < bound; c++) begin
         @(posedge clk);
         #1;
         if (gnt !== 4'b0000) begin
            seen = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!seen || gnt !== eg || owner !== eo || busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s: seen=%b gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=1",
                  nm, seen, gnt, owner, busy, eg, eo);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (gnt !== 4'b0000 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL %s pulse: gnt=%b tx=%b, want gnt=0000 tx=1",
                  nm, gnt, tx);
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input string nm,
                            input int pulse_bit, input logic [3:0] pmask);
      logic [9:0] f;
      bit         ok;
      f = {1'b1, d, 1'b0};
      for (int b = 0; b < FRAME_BITS; b++) begin
         tick_wait(ok);
         n_vec++;
         if (!ok || tx !== f[b] || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s bit%0d: tx=%b busy=%b tick_ok=%b, want tx=%b busy=1",
                     nm, b, tx, busy, ok, f[b]);
         end
         if (b == pulse_bit) begin
            req = req | pmask;
            @(posedge clk);
            #1;
            req = req & ~pmask;
            n_vec++;
            if (gnt !== 4'b0000) begin
               n_err++;
               $display("FAIL %s busy-req: gnt=%b, want 0000", nm, gnt);
            end
         end
      end
      tick_wait(ok);
      n_vec++;
      if (!ok || tx !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s end: tx=%b busy=%b tick_ok=%b, want tx=1 busy=0",
                  nm, tx, busy, ok);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      req        = 4'b0000;
      req_data   = 32'h0;
      tick_en    = 1'b0;
      tick_force = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL reset tx: got %b want 1", tx);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset busy: got %b want 0", busy);
      end
      n_vec++;
      if (gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL reset gnt: got %b want 0000", gnt);
      end
      n_vec++;
      if (owner !== 2'd0) begin
         n_err++;
         $display("FAIL reset owner: got %0d want 0", owner);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bit extra;
      tick_en        = 1'b1;
      req_data[7:0]  = 8'hA5;
      req            = 4'b0001;
      wait_gnt(4'b0001, 2'd0, 40, "single gnt");
      req = 4'b0000;
      run_frame(8'hA5, "single", -1, 4'b0000);
      extra = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (gnt !== 4'b0000 || busy !== 1'b0) extra = 1'b1;
      end
      n_vec++;
      if (extra) begin
         n_err++;
         $display("FAIL single idle: activity after frame, gnt=%b busy=%b want 0",
                  gnt, busy);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] pd [4];
      int         idx;
      pd[0] = 8'h11;
      pd[1] = 8'h22;
      pd[2] = 8'h33;
      pd[3] = 8'h44;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      req_data = {pd[3], pd[2], pd[1], pd[0]};
      req      = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         idx = k % 4;
         wait_gnt(4'(1 << idx), 2'(idx), (k == 0) ? 40 : 1,
                  $sformatf("rr gnt%0d", k));
         if (k == 4) req = 4'b0000;
         run_frame(pd[idx], $sformatf("rr frame%0d", k), -1, 4'b0000);
      end
   endtask

   task automatic test_coincident();
      tick_en          = 1'b0;
      tick_force       = 1'b1;
      req_data[23:16]  = 8'h5A;
      req              = 4'b0100;
      wait_gnt(4'b0100, 2'd2, 4, "coinc gnt");
      tick_force = 1'b0;
      tick_en    = 1'b1;
      req        = 4'b0000;
      run_frame(8'h5A, "coinc", -1, 4'b0000);
   endtask

   task automatic test_busy_pulse();
      req_data[7:0] = 8'hC3;
      req           = 4'b0001;
      wait_gnt(4'b0001, 2'd0, 40, "busy gnt0");
      req = 4'b0000;
      run_frame(8'hC3, "busy", 3, 4'b0010);
      req_data[15:8]  = 8'h96;
      req_data[31:24] = 8'h69;
      req             = 4'b1010;
      wait_gnt(4'b0010, 2'd1, 40, "ptr kept");
      req = 4'b0000;
      run_frame(8'h96, "ptr frame", -1, 4'b0000);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit ok_all;
      bit leak;
      req_data[7:0] = 8'hF0;
      req           = 4'b0001;
      wait_gnt(4'b0001, 2'd0, 40, "mid gnt");
      req    = 4'b0000;
      ok_all = 1'b1;
      for (int b = 0; b < 5; b++) begin
         tick_wait(ok);
         ok_all = ok_all && ok;
      end
      n_vec++;
      if (!ok_all || tx !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid d3: tx=%b busy=%b tick_ok=%b, want tx=0 busy=1",
                  tx, busy, ok_all);
      end
      reset = 1'b1;
      req   = 4'b1111;
      #1;
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL mid abort: tx=%b busy=%b gnt=%b, want tx=1 busy=0 gnt=0000",
                  tx, busy, gnt);
      end
      leak = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (gnt !== 4'b0000 || busy !== 1'b0 || tx !== 1'b1) leak = 1'b1;
      end
      n_vec++;
      if (leak || owner !== 2'd0) begin
         n_err++;
         $display("FAIL mid hold: activity under reset, owner=%0d gnt=%b, want 0/0000",
                  owner, gnt);
      end
      req_data[23:16] = 8'h3C;
      req             = 4'b0100;
      reset           = 1'b0;
      wait_gnt(4'b0100, 2'd2, 40, "mid regrant");
      req = 4'b0000;
      run_frame(8'h3C, "mid frame", -1, 4'b0000);
   endtask

   initial begin
      reset    = 1'b1;
      req      = 4'b0000;
      req_data = 32'h0;
      test_reset();
      test_single();
      test_round_robin();
      test_coincident();
      test_busy_pulse();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
